// File: rtl/string_byte_feeder_if.sv
// Stream interface carrying 32-bit text words from the DMA into the byte
// feeder. The master drives data/keep/valid/last, the slave drives ready.
interface string_byte_feeder_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/string_byte_feeder.sv
// string_byte_feeder: unpacks 32-bit stream words into one byte per cycle for
// the string matcher and frames each batch with proc_start / proc_last.
// proc_last is held back DRAIN_CYCLES after the final byte so the MD5 pipeline
// downstream has drained before the batch is declared complete.
// Optional macro STRING_BYTE_FEEDER_SWAP_EN: emit lanes big-endian
// ([31:24] first, tkeep contiguous from bit 3). Default is lane 0 first.
module string_byte_feeder #(
  parameter int DRAIN_CYCLES = 70,
  parameter int CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_go,
  input  logic                 cmd_abort,
  string_byte_feeder_if.slave  s,
  output logic                 proc_start,
  output logic [7:0]           proc_data,
  output logic                 proc_data_valid,
  output logic                 proc_last,
  input  logic                 proc_ready,
  output logic                 feed_busy,
  output logic [CNT_W-1:0]     feed_byte_count
);

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_RDY, STREAM, DRAIN, LAST} state_t;

  state_t             state_reg, state_next;
  logic [31:0]        buf_data_reg;
  logic [1:0]         buf_end_reg;     // emit index of the final kept byte
  logic               buf_tlast_reg;
  logic               buf_full_reg;
  logic [1:0]         ptr_reg;
  logic [DRAIN_W-1:0] drain_cnt_reg;
  logic               proc_start_reg, proc_data_valid_reg, proc_last_reg, busy_reg;
  logic [7:0]         proc_data_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               emit, final_emit, tready, accept, abort_hit;
  logic [7:0]         lane [4];

  // lane[i] is the i-th byte in emission order
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
`ifdef STRING_BYTE_FEEDER_SWAP_EN
      assign lane[gi] = buf_data_reg[8*(3-gi) +: 8];
`else
      assign lane[gi] = buf_data_reg[8*gi +: 8];
`endif
    end
  endgenerate

  // Emission index of the last kept byte for a contiguous tkeep
  function automatic logic [1:0] end_index(input logic [3:0] keep);
`ifdef STRING_BYTE_FEEDER_SWAP_EN
    if (keep[0])      return 2'd3;
    else if (keep[1]) return 2'd2;
    else if (keep[2]) return 2'd1;
    else              return 2'd0;
`else
    if (keep[3])      return 2'd3;
    else if (keep[2]) return 2'd2;
    else if (keep[1]) return 2'd1;
    else              return 2'd0;
`endif
  endfunction

  // Next state plus the per-cycle handshake/emit decisions
  always_comb begin
    state_next = state_reg;
    abort_hit  = 1'b0;
    emit       = 1'b0;
    final_emit = 1'b0;
    tready     = 1'b0;
    accept     = 1'b0;

    abort_hit  = cmd_abort && (state_reg == START || state_reg == WAIT_RDY ||
                               state_reg == STREAM || state_reg == DRAIN);
    emit       = (state_reg == STREAM) && buf_full_reg && proc_ready && !cmd_abort;
    final_emit = emit && (ptr_reg == buf_end_reg);
    // Once the tlast word is buffered, nothing more is taken for this batch
    tready     = (state_reg == STREAM) && !cmd_abort &&
                 (!buf_full_reg || (final_emit && !buf_tlast_reg));
    accept     = s.tvalid && tready;

    case (state_reg)
      IDLE:     if (cmd_go && !cmd_abort) state_next = START;
      START:    state_next = abort_hit ? LAST : WAIT_RDY;
      WAIT_RDY: if (abort_hit) state_next = LAST;
                else if (proc_ready) state_next = STREAM;
      STREAM:   if (abort_hit) state_next = LAST;
                else if (final_emit && buf_tlast_reg) state_next = DRAIN;
                else if (accept && s.tlast && (s.tkeep == 4'b0000)) state_next = DRAIN;
      DRAIN:    if (abort_hit || (drain_cnt_reg == '0)) state_next = LAST;
      LAST:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign s.tready = tready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // Word buffer, lane pointer, drain timer, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_data_reg        <= '0;
      buf_end_reg         <= '0;
      buf_tlast_reg       <= 1'b0;
      buf_full_reg        <= 1'b0;
      ptr_reg             <= '0;
      drain_cnt_reg       <= '0;
      proc_start_reg      <= 1'b0;
      proc_data_reg       <= '0;
      proc_data_valid_reg <= 1'b0;
      proc_last_reg       <= 1'b0;
      busy_reg            <= 1'b0;
      count_reg           <= '0;
    end else begin
      proc_start_reg      <= (state_next == START);
      proc_last_reg       <= (state_next == LAST);
      busy_reg            <= (state_next != IDLE);
      proc_data_valid_reg <= emit;
      if (emit) proc_data_reg <= lane[ptr_reg];

      if (state_reg == IDLE && cmd_go && !cmd_abort) count_reg <= '0;
      else if (emit)                                 count_reg <= count_reg + CNT_W'(1);

      if (abort_hit || state_next != STREAM) begin
        buf_full_reg  <= 1'b0;
        buf_tlast_reg <= 1'b0;
        ptr_reg       <= '0;
      end else if (accept) begin
        buf_data_reg  <= s.tdata;
        buf_end_reg   <= end_index(s.tkeep);
        buf_tlast_reg <= s.tlast;
        buf_full_reg  <= |s.tkeep;
        ptr_reg       <= '0;
      end else if (final_emit) begin
        buf_full_reg  <= 1'b0;
        ptr_reg       <= '0;
      end else if (emit) begin
        ptr_reg       <= ptr_reg + 2'd1;
      end

      if (state_reg != DRAIN && state_next == DRAIN)
        drain_cnt_reg <= DRAIN_W'(DRAIN_CYCLES);
      else if (state_reg == DRAIN && drain_cnt_reg != '0)
        drain_cnt_reg <= drain_cnt_reg - DRAIN_W'(1);
    end
  end

  assign proc_start      = proc_start_reg;
  assign proc_data       = proc_data_reg;
  assign proc_data_valid = proc_data_valid_reg;
  assign proc_last       = proc_last_reg;
  assign feed_busy       = busy_reg;
  assign feed_byte_count = count_reg;

endmodule

// File: tb/tb_string_byte_feeder.sv
// Scoreboard bench for string_byte_feeder: stimulus pushes expected bytes,
// a negedge monitor pops and compares every proc_data_valid byte.
module tb_string_byte_feeder;
  localparam int DRAIN = 70;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_go = 1'b0, cmd_abort = 1'b0, proc_ready = 1'b1;
  logic        proc_start, proc_data_valid, proc_last, feed_busy;
  logic [7:0]  proc_data;
  logic [31:0] feed_byte_count;

  string_byte_feeder_if sif ();

  string_byte_feeder #(.DRAIN_CYCLES(DRAIN), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_go(cmd_go), .cmd_abort(cmd_abort), .s(sif),
    .proc_start(proc_start), .proc_data(proc_data), .proc_data_valid(proc_data_valid),
    .proc_last(proc_last), .proc_ready(proc_ready), .feed_busy(feed_busy),
    .feed_byte_count(feed_byte_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic [7:0] exp_q[$];
  int cyc = 0, valid_total = 0, runs = 0, tready_total = 0, last_total = 0, last_valid_cyc = 0;
  bit prev_valid = 0, stop_tx = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  function automatic void fail_now(input string name);
    n_total++;
    $display("FAIL %s: got timeout expected event", name);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (proc_data_valid) begin
      valid_total++;
      last_valid_cyc = cyc;
      if (!prev_valid) runs++;
      if (exp_q.size() == 0) check("unexpected_byte", {24'd0, proc_data}, 32'hxxxx_xxxx);
      else check("byte", {24'd0, proc_data}, {24'd0, exp_q.pop_front()});
      $display("byte %02h count=%0d", proc_data, feed_byte_count);
    end
    prev_valid = proc_data_valid;
    if (sif.tready) tready_total++;
    if (proc_last) last_total++;
  end

  task automatic push_word(input logic [31:0] d, input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) exp_q.push_back(d[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit done = 0;
    int n = 0;
    sif.tdata = d; sif.tkeep = k; sif.tlast = l; sif.tvalid = 1'b1;
    while (!done && !stop_tx && n < 200) begin
      @(negedge clk); #1;
      if (sif.tready) begin @(posedge clk); #1; done = 1; end
      n++;
    end
    if (!done && !stop_tx) fail_now("handshake");
  endtask

  task automatic go();
    @(posedge clk); #1 cmd_go = 1'b1;
    @(posedge clk); #1 cmd_go = 1'b0;
    @(negedge clk); #1;
    check("start_pulse", proc_start, 1'b1);
    check("busy_at_start", feed_busy, 1'b1);
    check("count_cleared", feed_byte_count, 32'd0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("start_one_cycle", proc_start, 1'b0);
  endtask

  task automatic wait_last(output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (proc_last) begin at = cyc; break; end
    end
    if (at < 0) fail_now("proc_last");
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (valid_total < target && n < 300) begin @(negedge clk); #1; n++; end
    if (valid_total < target) fail_now("byte_wait");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int at, v0, snap, l0, t0, r0;
    logic [31:0] w;
    sif.tdata = '0; sif.tkeep = '0; sif.tvalid = 1'b0; sif.tlast = 1'b0;

    // Reset state
    #12;
    check("rst_start", proc_start, 1'b0);
    check("rst_valid", proc_data_valid, 1'b0);
    check("rst_data", proc_data, 8'h00);
    check("rst_last", proc_last, 1'b0);
    check("rst_busy", feed_busy, 1'b0);
    check("rst_count", feed_byte_count, 32'd0);
    check("rst_tready", sif.tready, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Basic two-word batch
    go();
    push_word(32'h64636261, 4'hF); push_word(32'h68676665, 4'hF);
    send_word(32'h64636261, 4'hF, 1'b0);
    send_word(32'h68676665, 4'hF, 1'b1);
    sif.tvalid = 1'b0;
    wait_last(at);
    check("last_latency", at - last_valid_cyc, DRAIN + 1);
    check("count_8", feed_byte_count, 32'd8);
    check("busy_in_last", feed_busy, 1'b1);
    @(negedge clk); #1;
    check("last_one_cycle", proc_last, 1'b0);
    check("busy_drop", feed_busy, 1'b0);
    check("queue_empty_1", exp_q.size(), 0);

    // Partial final word
    go();
    push_word(32'h00636261, 4'b0111);
    send_word(32'h00636261, 4'b0111, 1'b1);
    sif.tvalid = 1'b0;
    wait_last(at);
    check("count_3", feed_byte_count, 32'd3);
    check("queue_empty_2", exp_q.size(), 0);

    // Empty tlast word
    v0 = valid_total;
    go();
    send_word(32'h0, 4'b0000, 1'b1);
    sif.tvalid = 1'b0;
    wait_last(at);
    check("empty_no_bytes", valid_total - v0, 0);
    check("count_0", feed_byte_count, 32'd0);

    // 1000 back-to-back words
    v0 = valid_total; t0 = tready_total; r0 = runs;
    go();
    for (int i = 0; i < 1000; i++) begin
      w = $urandom;
      push_word(w, 4'hF);
      send_word(w, 4'hF, i == 999);
    end
    sif.tvalid = 1'b0;
    wait_last(at);
    check("stream_bytes", valid_total - v0, 4000);
    check("stream_no_gaps", runs - r0, 1);
    check("stream_tready", tready_total - t0, 1000);
    check("count_4000", feed_byte_count, 32'd4000);

    // Five-cycle stall mid-word
    v0 = valid_total;
    go();
    push_word(32'h44332211, 4'hF); push_word(32'h88776655, 4'hF);
    fork
      begin
        send_word(32'h44332211, 4'hF, 1'b0);
        send_word(32'h88776655, 4'hF, 1'b1);
        sif.tvalid = 1'b0;
      end
      begin
        wait_bytes(v0 + 2);
        @(posedge clk); #1 proc_ready = 1'b0;
        @(posedge clk); #1 snap = valid_total;
        repeat (4) begin @(posedge clk); #1; end
        proc_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_no_bytes", valid_total - snap, 0);
      end
    join
    wait_last(at);
    check("stall_count", feed_byte_count, 32'd8);
    check("queue_empty_3", exp_q.size(), 0);

    // Abort in DRAIN with counter at 30
    v0 = valid_total;
    go();
    push_word(32'hDDCCBBAA, 4'hF);
    send_word(32'hDDCCBBAA, 4'hF, 1'b1);
    sif.tvalid = 1'b0;
    wait_bytes(v0 + 4);
    l0 = last_total;
    repeat (40) @(posedge clk);
    #1 cmd_abort = 1'b1;
    @(posedge clk); #1 cmd_abort = 1'b0;
    @(negedge clk); #1;
    check("abort_last", proc_last, 1'b1);
    check("abort_last_once", last_total - l0, 1);
    @(negedge clk); #1;
    check("abort_idle_busy", feed_busy, 1'b0);
    go();
    push_word(32'h000000EE, 4'b0001);
    send_word(32'h000000EE, 4'b0001, 1'b1);
    sif.tvalid = 1'b0;
    wait_last(at);
    check("after_abort_count", feed_byte_count, 32'd1);

    // Asynchronous reset mid-stream
    v0 = valid_total;
    go();
    fork
      begin
        for (int i = 0; i < 4 && !stop_tx; i++) begin
          push_word(32'h01020304 * (i + 1), 4'hF);
          send_word(32'h01020304 * (i + 1), 4'hF, i == 3);
        end
      end
      begin
        wait_bytes(v0 + 3);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check("arst_valid", proc_data_valid, 1'b0);
        check("arst_data", proc_data, 8'h00);
        check("arst_tready", sif.tready, 1'b0);
        check("arst_busy", feed_busy, 1'b0);
        check("arst_count", feed_byte_count, 32'd0);
        check("arst_last", proc_last, 1'b0);
        stop_tx = 1;
      end
    join
    exp_q.delete();
    sif.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    stop_tx = 0;
    l0 = last_total;
    repeat (100) @(negedge clk);
    #1;
    check("arst_no_last", last_total - l0, 0);
    check("arst_idle", feed_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
